// File: rtl/block_dispatcher.sv
// Splits a host-launched kernel into fixed-size thread blocks, hands them to
// compute cores lowest-free-first, and reports done once every block has completed.
module block_dispatcher #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4,
  localparam int TW               = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              thread_count,
  input  logic [NUM_CORES-1:0]    core_done,
  output logic [NUM_CORES-1:0]    core_start,
  output logic [NUM_CORES-1:0]    core_reset,
  output logic [NUM_CORES*8-1:0]  core_block_id,
  output logic [NUM_CORES*TW-1:0] core_thread_count,
  output logic                    done
);

  localparam int LOG2_TPB = $clog2(THREADS_PER_BLOCK);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]              state_r, state_n;
  logic [7:0]              tc_r, tc_n;
  logic [8:0]              total_r, total_n;
  logic [8:0]              disp_r, disp_n;
  logic [8:0]              comp_r, comp_n;
  logic [NUM_CORES-1:0]    busy_r, busy_n;
  logic [NUM_CORES-1:0]    core_reset_r;
  logic [NUM_CORES*8-1:0]  id_r, id_n;
  logic [NUM_CORES*TW-1:0] cnt_r, cnt_n;
  logic                    done_r, done_n;

  logic [NUM_CORES-1:0]    finish_s;
  logic [NUM_CORES-1:0]    pick_s;
  logic                    found_s;
  logic [8:0]              total_calc_s;
  logic [8:0]              remain_s;
  logic [TW-1:0]           blk_cnt_s;

  function automatic logic [8:0] popcount(input logic [NUM_CORES-1:0] v);
    logic [8:0] sum;
    sum = 9'd0;
    for (int i = 0; i < NUM_CORES; i++) begin
      sum = sum + {8'd0, v[i]};
    end
    return sum;
  endfunction

  // Block count, last-block size and lowest-index free core
  always_comb begin
    total_calc_s = ({1'b0, thread_count} + 9'(THREADS_PER_BLOCK - 1)) >> LOG2_TPB;
    remain_s     = {1'b0, tc_r} - (disp_r << LOG2_TPB);
    if (disp_r == (total_r - 9'd1)) begin
      blk_cnt_s = remain_s[TW-1:0];
    end else begin
      blk_cnt_s = TW'(THREADS_PER_BLOCK);
    end
    finish_s = busy_r & core_done;
    pick_s   = '0;
    found_s  = 1'b0;
    // Only cores already FREE this cycle qualify, so a just-finished core sees core_reset for a cycle
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!busy_r[i] && !found_s) begin
        pick_s[i] = 1'b1;
        found_s   = 1'b1;
      end else begin
        pick_s[i] = 1'b0;
      end
    end
  end

  // Next-state logic for the global FSM, counters and per-core slots
  always_comb begin
    state_n = state_r;
    tc_n    = tc_r;
    total_n = total_r;
    disp_n  = disp_r;
    comp_n  = comp_r + popcount(finish_s);
    busy_n  = busy_r & ~finish_s;
    id_n    = id_r;
    cnt_n   = cnt_r;
    done_n  = done_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_RUN;
          tc_n    = thread_count;
          total_n = total_calc_s;
          disp_n  = 9'd0;
          comp_n  = 9'd0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (comp_r == total_r) begin
          state_n = ST_DONE;
          done_n  = 1'b1;
        end else if ((disp_r < total_r) && found_s) begin
          disp_n = disp_r + 9'd1;
          for (int i = 0; i < NUM_CORES; i++) begin
            if (pick_s[i]) begin
              busy_n[i]           = 1'b1;
              id_n[i*8 +: 8]      = disp_r[7:0];
              cnt_n[i*TW +: TW]   = blk_cnt_s;
            end else begin
              busy_n[i] = busy_n[i];
            end
          end
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_DONE: begin
        if (!start) begin
          state_n = ST_IDLE;
          done_n  = 1'b0;
        end else begin
          state_n = ST_DONE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        done_n  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      tc_r         <= 8'd0;
      total_r      <= 9'd0;
      disp_r       <= 9'd0;
      comp_r       <= 9'd0;
      busy_r       <= '0;
      core_reset_r <= '1;
      id_r         <= '0;
      cnt_r        <= '0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_n;
      tc_r         <= tc_n;
      total_r      <= total_n;
      disp_r       <= disp_n;
      comp_r       <= comp_n;
      busy_r       <= busy_n;
      core_reset_r <= ~busy_n;
      id_r         <= id_n;
      cnt_r        <= cnt_n;
      done_r       <= done_n;
    end
  end

  assign core_start        = busy_r;
  assign core_reset        = core_reset_r;
  assign core_block_id     = id_r;
  assign core_thread_count = cnt_r;
  assign done              = done_r;

endmodule
